imem_arbiter: RTL and testbench

- Sequences and shares the single-port instruction memory between two requesters:
  - the program loader, which writes;
  - the fetch unit, which reads.
- Boot phase (LOAD): only the loader may access memory.
- Run phase (RUN): loader has priority, with a bounded starvation guard for fetch.
- Sits between the loader/fetch logic and the IMEM instance; drives its address, write-enable and write-data, and returns read data with a valid strobe.

---
 rtl/imem_arbiter_if.sv | 42 ++++
 rtl/imem_arbiter.sv | 143 ++++++++++++++
 tb/tb_imem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the loader/fetch requesters, the IMEM arbiter and the
// instruction memory. The arbiter uses the slave view. The master view drives
// requests and supplies memory read data (requesters plus memory).
interface imem_arbiter_if #(
  parameter int WIDTH = 32
);
  // Loader (write) channel
  logic             ld_req;
  logic [WIDTH-1:0] ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             ld_done;
  logic             ld_gnt;

  // Fetch (read) channel
  logic             f_req;
  logic [WIDTH-1:0] f_addr;
  logic             f_gnt;
  logic             f_rvalid;
  logic [WIDTH-1:0] f_rdata;

  // Status
  logic             err_oob;
  logic             running;

  // Memory port
  logic [WIDTH-1:0] mem_addr;
  logic             mem_wre;
  logic [WIDTH-1:0] mem_wr_data;
  logic [WIDTH-1:0] mem_rd_data;

  modport slave (
    input  ld_req, ld_addr, ld_data, ld_done, f_req, f_addr, mem_rd_data,
    output ld_gnt, f_gnt, f_rvalid, f_rdata, err_oob, running,
           mem_addr, mem_wre, mem_wr_data
  );

  modport master (
    output ld_req, ld_addr, ld_data, ld_done, f_req, f_addr, mem_rd_data,
    input  ld_gnt, f_gnt, f_rvalid, f_rdata, err_oob, running,
           mem_addr, mem_wre, mem_wr_data
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between the program loader
// (writes) and the fetch unit (reads). In LOAD only the loader gets the
// memory. In RUN the loader has priority, but fetch is forced through after
// STARVE_LIM consecutive denied cycles.
//
// Handshake: req/gnt. A requester raises req and holds it, with its address
// and data, until it sees gnt. gnt is combinational in the same cycle. A
// transfer happens in exactly the cycles where req && gnt. Requests are not
// latched. Read data returns one cycle after a fetch grant, marked by
// f_rvalid, one pulse per grant, in grant order.
module imem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int STARVE_LIM = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  imem_arbiter_if.slave                       bus,
  output logic                                dbg_state,
  output logic [$clog2(STARVE_LIM+1)-1:0]     dbg_starve_cnt
);

  localparam int               CNT_W   = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);
  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rvalid_q, rvalid_d;
  logic             rd_oob_q, rd_oob_d;
  logic             err_oob_q, err_oob_d;

  logic             ld_gnt;
  logic             f_gnt;
  logic             ld_oob;
  logic             f_oob;

  assign ld_oob = (bus.ld_addr >= DEPTH_W);
  assign f_oob  = (bus.f_addr >= DEPTH_W);

  // Grant decision: nothing is granted during reset. LOAD is loader-only.
  // RUN is loader-first, with the starvation override for fetch.
  always_comb begin
    ld_gnt = 1'b0;
    f_gnt  = 1'b0;
    if (!rst) begin
      case (state_q)
        LOAD: begin
          ld_gnt = bus.ld_req;
        end
        RUN: begin
          if ((starve_cnt_q == CNT_MAX) && bus.f_req) begin
            f_gnt = 1'b1;
          end else if (bus.ld_req) begin
            ld_gnt = 1'b1;
          end else begin
            f_gnt = bus.f_req;
          end
        end
        default: begin
          ld_gnt = 1'b0;
          f_gnt  = 1'b0;
        end
      endcase
    end
  end

  // Memory port drive. An out-of-range write keeps the address but suppresses
  // the write strobe, so the access is dropped and only flagged.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wre     = 1'b0;
    bus.mem_wr_data = '0;
    if (ld_gnt) begin
      bus.mem_addr    = bus.ld_addr;
      bus.mem_wr_data = bus.ld_data;
      bus.mem_wre     = !ld_oob;
    end else if (f_gnt) begin
      bus.mem_addr = bus.f_addr;
    end
  end

  // Next state: leave LOAD on ld_done. Only reset returns to LOAD.
  always_comb begin
    state_d = state_q;
    if ((state_q == LOAD) && bus.ld_done) begin
      state_d = RUN;
    end
  end

  // Starvation counter: counts cycles where fetch waits behind the loader.
  // It clears whenever fetch is served or stops asking, and stays at 0 in LOAD.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q != RUN) begin
      starve_cnt_d = '0;
    end else if (f_gnt || !bus.f_req) begin
      starve_cnt_d = '0;
    end else if (ld_gnt && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Read-return and error tracking for the cycle after a grant.
  always_comb begin
    rvalid_d  = f_gnt;
    rd_oob_d  = f_gnt && f_oob;
    err_oob_d = (ld_gnt && ld_oob) || (f_gnt && f_oob);
  end

  // State and pipeline registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      starve_cnt_q <= '0;
      rvalid_q     <= 1'b0;
      rd_oob_q     <= 1'b0;
      err_oob_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid_q     <= rvalid_d;
      rd_oob_q     <= rd_oob_d;
      err_oob_q    <= err_oob_d;
    end
  end

  assign bus.ld_gnt   = ld_gnt;
  assign bus.f_gnt    = f_gnt;
  assign bus.f_rvalid = rvalid_q;
  assign bus.f_rdata  = (rvalid_q && !rd_oob_q) ? bus.mem_rd_data : '0;
  assign bus.err_oob  = err_oob_q;
  assign bus.running  = (state_q == RUN);

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural single-port IMEM
// (registered read, out-of-range read returns a poison word).
module tb_imem_arbiter;

  localparam int WIDTH      = 32;
  localparam int DEPTH      = 256;
  localparam int STARVE_LIM = 4;

  logic       clk;
  logic       rst;
  logic       dbg_state;
  logic [2:0] dbg_starve_cnt;

  int tests_run;
  int tests_failed;

  logic [WIDTH-1:0] exp_q[$];

  imem_arbiter_if #(.WIDTH(WIDTH)) bus ();

  imem_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [WIDTH-1:0] tb_mem [0:DEPTH-1];
  logic [WIDTH-1:0] mem_rd_q;

  always @(posedge clk) begin
    if (bus.mem_wre && (bus.mem_addr < DEPTH))
      tb_mem[bus.mem_addr[7:0]] <= bus.mem_wr_data;
    mem_rd_q <= (bus.mem_addr < DEPTH) ? tb_mem[bus.mem_addr[7:0]] : 32'hDEAD_BEEF;
  end
  assign bus.mem_rd_data = mem_rd_q;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.ld_req = 1'b1; bus.ld_addr = 32'd5; bus.ld_data = 32'h77;
    bus.f_req = 1'b1; bus.f_addr = 32'd1; bus.ld_done = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (bus.ld_gnt !== 1'b0 || bus.f_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_gnt: ld_gnt=%b f_gnt=%b required 0 0", bus.ld_gnt, bus.f_gnt);
    end
    tests_run++;
    if (bus.mem_wre !== 1'b0 || bus.mem_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mem: wre=%b addr=%h required 0 0", bus.mem_wre, bus.mem_addr);
    end
    tests_run++;
    if (bus.f_rvalid !== 1'b0 || bus.err_oob !== 1'b0 || bus.running !== 1'b0 ||
        dbg_state !== 1'b0 || dbg_starve_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: rvalid=%b err=%b run=%b st=%b cnt=%0d required all 0",
               bus.f_rvalid, bus.err_oob, bus.running, dbg_state, dbg_starve_cnt);
    end
    bus.ld_req = 1'b0; bus.f_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_boot_load();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ld_req = 1'b1; bus.ld_addr = i; bus.ld_data = 32'h10 + i;
      bus.f_req = 1'b1; bus.f_addr = 32'd0;
      #1;
      tests_run++;
      if (bus.ld_gnt !== 1'b1 || bus.f_gnt !== 1'b0 || bus.running !== 1'b0) begin
        tests_failed++;
        $display("FAIL boot_gnt[%0d]: ld_gnt=%b f_gnt=%b run=%b required 1 0 0",
                 i, bus.ld_gnt, bus.f_gnt, bus.running);
      end
      tests_run++;
      if (bus.mem_wre !== 1'b1 || bus.mem_addr !== i || bus.mem_wr_data !== 32'h10 + i ||
          dbg_starve_cnt !== 3'd0) begin
        tests_failed++;
        $display("FAIL boot_mem[%0d]: wre=%b addr=%h data=%h cnt=%0d required 1 %h %h 0",
                 i, bus.mem_wre, bus.mem_addr, bus.mem_wr_data, dbg_starve_cnt, i, 32'h10 + i);
      end
    end
    @(negedge clk);
    bus.ld_req = 1'b0; bus.f_req = 1'b1; bus.f_addr = 32'd0;
    #1;
    tests_run++;
    if (bus.f_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_fetch_blocked: f_gnt=%b required 0", bus.f_gnt);
    end
  endtask

  task automatic test_transition_fetch();
    @(negedge clk);
    bus.ld_done = 1'b1; bus.f_req = 1'b1; bus.f_addr = 32'd2;
    #1;
    tests_run++;
    if (bus.f_gnt !== 1'b0 || bus.running !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_cycle_load_rules: f_gnt=%b run=%b required 0 0", bus.f_gnt, bus.running);
    end
    @(negedge clk);
    bus.ld_done = 1'b0;
    #1;
    tests_run++;
    if (bus.running !== 1'b1 || bus.f_gnt !== 1'b1 || bus.mem_addr !== 32'd2 || bus.mem_wre !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_fetch_gnt: run=%b f_gnt=%b addr=%h wre=%b required 1 1 2 0",
               bus.running, bus.f_gnt, bus.mem_addr, bus.mem_wre);
    end
    @(negedge clk);
    bus.f_req = 1'b0;
    #1;
    tests_run++;
    if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'h12) begin
      tests_failed++;
      $display("FAIL fetch_data: rvalid=%b rdata=%h required 1 12", bus.f_rvalid, bus.f_rdata);
    end
    @(negedge clk);
    bus.ld_done = 1'b1;
    #1;
    tests_run++;
    if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL fetch_idle: rvalid=%b rdata=%h required 0 0", bus.f_rvalid, bus.f_rdata);
    end
    @(negedge clk);
    bus.ld_done = 1'b0;
    #1;
    tests_run++;
    if (bus.running !== 1'b1 || dbg_state !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_in_run_ignored: run=%b st=%b required 1 1", bus.running, dbg_state);
    end
  endtask

  task automatic test_contention();
    logic       exp_ld [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] exp_cnt[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 32'd10; bus.ld_data = 32'hAA;
    bus.f_req = 1'b1; bus.f_addr = 32'd1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      tests_run++;
      if (bus.ld_gnt !== exp_ld[k] || bus.f_gnt !== !exp_ld[k] || dbg_starve_cnt !== exp_cnt[k]) begin
        tests_failed++;
        $display("FAIL contention[%0d]: ld_gnt=%b f_gnt=%b cnt=%0d required %b %b %0d",
                 k, bus.ld_gnt, bus.f_gnt, dbg_starve_cnt, exp_ld[k], !exp_ld[k], exp_cnt[k]);
      end
    end
    tests_run++;
    if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'h11) begin
      tests_failed++;
      $display("FAIL contention_rdata: rvalid=%b rdata=%h required 1 11", bus.f_rvalid, bus.f_rdata);
    end
    @(negedge clk);
    bus.ld_req = 1'b0; bus.f_req = 1'b0;
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'd300;
    #1;
    tests_run++;
    if (bus.f_gnt !== 1'b1 || bus.mem_addr !== 32'd300) begin
      tests_failed++;
      $display("FAIL oob_fetch_gnt: f_gnt=%b addr=%h required 1 12c", bus.f_gnt, bus.mem_addr);
    end
    @(negedge clk);
    bus.f_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_addr = 32'd256; bus.ld_data = 32'h55;
    #1;
    tests_run++;
    if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'd0 || bus.err_oob !== 1'b1) begin
      tests_failed++;
      $display("FAIL oob_fetch_resp: rvalid=%b rdata=%h err=%b required 1 0 1",
               bus.f_rvalid, bus.f_rdata, bus.err_oob);
    end
    tests_run++;
    if (bus.ld_gnt !== 1'b1 || bus.mem_wre !== 1'b0) begin
      tests_failed++;
      $display("FAIL oob_write_drop: ld_gnt=%b wre=%b required 1 0", bus.ld_gnt, bus.mem_wre);
    end
    @(negedge clk);
    bus.ld_req = 1'b0;
    #1;
    tests_run++;
    if (bus.err_oob !== 1'b1 || bus.f_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL oob_write_err: err=%b rvalid=%b required 1 0", bus.err_oob, bus.f_rvalid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.err_oob !== 1'b0 || tb_mem[0] !== 32'h10) begin
      tests_failed++;
      $display("FAIL oob_after: err=%b mem0=%h required 0 10", bus.err_oob, tb_mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp;
    int               got;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.f_req  = (i < 4);
      bus.f_addr = i;
      #1;
      if (bus.f_rvalid === 1'b1) begin
        tests_run++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        got++;
        if (bus.f_rdata !== exp) begin
          tests_failed++;
          $display("FAIL stream_data[%0d]: rdata=%h required %h", i, bus.f_rdata, exp);
        end
      end
      if (i < 4) begin
        tests_run++;
        if (bus.f_gnt !== 1'b1) begin
          tests_failed++;
          $display("FAIL stream_gnt[%0d]: f_gnt=%b required 1", i, bus.f_gnt);
        end
        exp_q.push_back(32'h10 + i);
      end
      if (i >= 1 && i <= 4) begin
        tests_run++;
        if (bus.f_rvalid !== 1'b1) begin
          tests_failed++;
          $display("FAIL stream_rvalid[%0d]: rvalid=%b required 1", i, bus.f_rvalid);
        end
      end
    end
    tests_run++;
    if (got != 4 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stream_count: responses=%0d pending=%0d required 4 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    rst = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 32'd1;
    bus.ld_req = 1'b1; bus.ld_addr = 32'd0; bus.ld_data = 32'h99;
    #1;
    tests_run++;
    if (bus.f_gnt !== 1'b0 || bus.ld_gnt !== 1'b0 || bus.mem_wre !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_gnt: f_gnt=%b ld_gnt=%b wre=%b required 0 0 0",
               bus.f_gnt, bus.ld_gnt, bus.mem_wre);
    end
    @(negedge clk);
    rst = 1'b0; bus.ld_req = 1'b0;
    #1;
    tests_run++;
    if (bus.f_rvalid !== 1'b0 || bus.running !== 1'b0 || dbg_state !== 1'b0 || bus.f_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_after: rvalid=%b run=%b st=%b f_gnt=%b required 0 0 0 0",
               bus.f_rvalid, bus.running, dbg_state, bus.f_gnt);
    end
    tests_run++;
    if (tb_mem[0] !== 32'h10) begin
      tests_failed++;
      $display("FAIL midrst_no_write: mem0=%h required 10", tb_mem[0]);
    end
    @(negedge clk);
    bus.ld_done = 1'b1;
    #1;
    tests_run++;
    if (bus.f_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_blocked: f_gnt=%b required 0", bus.f_gnt);
    end
    @(negedge clk);
    bus.ld_done = 1'b0;
    #1;
    tests_run++;
    if (bus.f_gnt !== 1'b1 || bus.running !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_resume: f_gnt=%b run=%b required 1 1", bus.f_gnt, bus.running);
    end
    @(negedge clk);
    bus.f_req = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.ld_req   = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_done = 1'b0;
    bus.f_req    = 1'b0; bus.f_addr  = '0;
    test_reset();
    test_boot_load();
    test_transition_fetch();
    test_contention();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
